// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of DEPTH entries with synchronous flush, full/empty flags and count.
// A flush overrides push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests, queues in-order responses, handles redirects.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   q_count, pend_count;
  logic [CW:0]     occ_sum;
  logic            q_full, q_empty, pend_full, pend_empty;
  entry_t          q_head, q_push_data;
  logic [XLEN-1:0] pend_head;
  logic            fire, resp_accept, bypass, q_push, q_pop;
  logic            unused_flags;

  // Space is reserved at request time: queued entries plus outstanding requests never exceed DEPTH.
  assign occ_sum        = {1'b0, q_count} + {1'b0, inflight_q};
  assign imem_req_valid = !reset && !redirect_valid && (occ_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign resp_accept = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
  assign bypass = !reset && resp_accept && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q_push      = resp_accept && !(bypass && out_ready);
  assign q_pop       = !q_empty && out_ready && !redirect_valid;
  assign q_push_data = '{pc: pend_head, instr: imem_resp_data};

  assign out_valid = !reset && ((!q_empty && !redirect_valid) || bypass);
  assign out_pc    = bypass ? pend_head      : (q_empty ? '0 : q_head.pc);
  assign out_instr = bypass ? imem_resp_data : (q_empty ? '0 : q_head.instr);

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    if (fire)           pc_d = pc_q + XLEN'(PC_STEP);
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    case ({fire, imem_resp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    // Every request still unanswered after this cycle belongs to the abandoned path.
    if (redirect_valid) begin
      drop_cnt_d = inflight_q - CW'(imem_resp_valid);
    end else if (imem_resp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Request addresses waiting for their response, in issue order.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (logic [XLEN-1:0])
  ) u_pending (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fire),
    .push_data (pc_q),
    .pop       (resp_accept),
    .head      (pend_head),
    .full      (pend_full),
    .empty     (pend_empty),
    .count     (pend_count)
  );

  assign unused_flags = ^{q_full, pend_full, pend_empty, pend_count, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-configurable in-order memory model.
module tb_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready = 1'b1;
  logic            imem_resp_valid = 1'b0;
  logic [XLEN-1:0] imem_resp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready = 1'b1;

  fetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int lat      = 1;
  int cyc      = 0;
  int fire_cnt = 0;
  int base;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0020) ? 32'h00A0_0093 : ~a;
  endfunction

  // Memory accepts on the edge, answers in order `lat` cycles later; reset drops everything.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + lat - 1});
      fire_cnt = fire_cnt + 1;
    end
  end

  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_out(input string tag, input int budget);
    for (int i = 0; i < budget && !out_valid; i++) tick();
    check(tag, out_valid, 1'b1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
  endtask

  logic [31:0] exp_pc    [3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
  logic [31:0] exp_instr [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Straight-line fetch, memory always ready, 1-cycle response.
    lat   = 1;
    reset = 1'b0;
    #1;
    check("seq_first_req_valid", imem_req_valid, 1'b1);
    check("seq_first_req_addr", imem_req_addr, 32'h0);
    check("seq_c0_out_valid", out_valid, 1'b0);
    for (int i = 1; i < FIRST_VALID; i++) begin
      tick();
      check($sformatf("seq_c%0d_out_valid", i), out_valid, 1'b0);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("seq%0d_out_valid", k), out_valid, 1'b1);
      check($sformatf("seq%0d_out_pc", k), out_pc, exp_pc[k]);
      check($sformatf("seq%0d_out_instr", k), out_instr, exp_instr[k]);
      if (k < 2) tick();
    end

    // Decode stalled: exactly DEPTH requests, then one per dequeue.
    do_reset();
    out_ready = 1'b0;
    base = fire_cnt;
    repeat (10) tick();
    check("stall_fires", fire_cnt - base, 4);
    check("stall_req_valid", imem_req_valid, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (4) tick();
    check("stall_fires_after_deq", fire_cnt - base, 5);
    check("stall_head_pc_after_deq", out_pc, 32'h4);
    check("stall_req_valid_after_deq", imem_req_valid, 1'b0);

    // Redirect with two requests in flight: both responses dropped.
    lat = 3;
    do_reset();
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_to(32'h0000_0103);
    check("redir_req_valid", imem_req_valid, 1'b0);
    check("redir_out_valid", out_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("redir_next_req_valid", imem_req_valid, 1'b1);
    check("redir_next_req_addr", imem_req_addr, 32'h0000_0100);
    wait_out("redir_wait_out", 20);
    check("redir_out_pc0", out_pc, 32'h0000_0100);
    check("redir_out_instr0", out_instr, 32'hFFFF_FEFF);
    tick();
    check("redir_out_pc1", out_pc, 32'h0000_0104);
    check("redir_out_instr1", out_instr, 32'hFFFF_FEFB);

    // Redirect while the head is being accepted: flushed, not consumed.
    lat = 1;
    do_reset();
    out_ready = 1'b0;
    repeat (8) tick();
    check("flush_full_req_valid", imem_req_valid, 1'b0);
    out_ready = 1'b1;
    redirect_to(32'h0000_0200);
    check("flush_redir_out_valid", out_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("flush_empty_out_valid", out_valid, 1'b0);
    check("flush_req_addr", imem_req_addr, 32'h0000_0200);
    wait_out("flush_wait_out", 10);
    check("flush_out_pc", out_pc, 32'h0000_0200);

    // Redirect with a response arriving in the same cycle, then PC wrap-around.
    repeat (3) tick();
    redirect_to(32'hFFFF_FFFF);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
    wait_out("wrap_wait_out", 10);
    check("wrap_out_pc0", out_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_out_pc1", out_pc, 32'h0000_0000);
    check("wrap_out_instr1", out_instr, 32'hFFFF_FFFF);

    // Response at PC 0x20 reaching an empty queue.
    repeat (3) tick();
    redirect_to(32'h0000_0020);
    tick();
    redirect_valid = 1'b0;
    #1;
    tick();
`ifdef FETCH_BYPASS_EN
    check("byp_out_valid", out_valid, 1'b1);
    check("byp_out_pc", out_pc, 32'h0000_0020);
    check("byp_out_instr", out_instr, 32'h00A0_0093);
`else
    check("nobyp_resp_cycle_out_valid", out_valid, 1'b0);
    tick();
    check("nobyp_out_valid", out_valid, 1'b1);
    check("nobyp_out_pc", out_pc, 32'h0000_0020);
    check("nobyp_out_instr", out_instr, 32'h00A0_0093);
`endif

    // Reset mid-operation with requests outstanding.
    lat = 3;
    repeat (2) tick();
    do_reset();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    wait_out("midrst_wait_out", 20);
    check("midrst_out_pc", out_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and instruction width.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_addr  out  XLEN  fetch address, word aligned.
REQ-008 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-009 imem_resp_valid  in  1  in-order response valid; no backpressure.
REQ-010 imem_resp_data  in  XLEN  instruction word.
REQ-011 redirect_valid  in  1  branch/jump redirect.
REQ-012 redirect_pc  in  XLEN  redirect target.
REQ-013 out_valid  out  1  decode-bound entry valid.
REQ-014 out_pc  out  XLEN  PC of the entry.
REQ-015 out_instr  out  XLEN  instruction of the entry.
REQ-016 out_ready  in  1  decode accepts; replaces the old stall flag.

Function
REQ-017 Request fires when imem_req_valid && imem_req_ready; fetch PC then advances by 4, wrapping modulo 2^XLEN.
REQ-018 imem_req_valid is high only when occupancy + inflight < DEPTH and redirect_valid is low; space is reserved at request time, so the queue never overflows.
REQ-019 inflight counts issued, unanswered requests and is $clog2(DEPTH)+1 bits wide; it increments on a fire, decrements on a response, and is unchanged when both happen in one cycle.
REQ-020 Queue entry {pc, instr}: pc is the request address, held in an in-order pending-address FIFO; entries are written on a non-dropped response.
REQ-021 Dequeue on out_valid && out_ready; enqueue and dequeue in the same cycle keep occupancy unchanged, including when the queue is full.
REQ-022 out_valid equals (queue non-empty) && !redirect_valid; out_pc and out_instr show the head entry.
REQ-023 Redirect cycle: the queue and pending-address FIFO are flushed; fetch PC <= {redirect_pc[XLEN-1:2], 2'b00}; no dequeue takes effect.
REQ-024 Redirect cycle: drop_cnt <= inflight, minus 1 if a response arrives that cycle; the next drop_cnt responses are discarded and each decrements drop_cnt.
REQ-025 A redirect while drop_cnt > 0 recomputes drop_cnt by the same rule.
REQ-026 First request at the redirect target is issued no earlier than the cycle after the redirect.
REQ-027 Minimum latency: response edge to out_valid is 1 cycle (without bypass).

Reset
REQ-028 On reset:
  - fetch PC = RESET_PC;
  - occupancy, inflight and drop_cnt = 0;
  - out_valid = 0, imem_req_valid = 0;
  - out_pc = 0, out_instr = 0.
REQ-029 Reset asserted mid-operation abandons all in-flight responses; the memory is reset at the same time.
REQ-030 First request is issued in the first cycle after reset deasserts.

Configuration
REQ-031 Macro FETCH_BYPASS_EN, when defined:
  - condition: queue empty, drop_cnt = 0, no redirect, a response arriving;
  - out_valid is asserted in the same cycle, with pc/instr taken from the response;
  - if out_ready is high, nothing is enqueued.
REQ-032 Without FETCH_BYPASS_EN, every response passes through the queue with 1-cycle latency.

Structure
REQ-033 Package fetch_pkg holds:
  - typedef fetch_entry_t {pc, instr};
  - constant PC_STEP = 4;
  - the default RESET_PC value.
REQ-034 Sub-module fetch_fifo: parametrised DEPTH x fetch_entry_t circular buffer with flush, full/empty flags and count, instantiated for the queue; the pending-address FIFO is a separate instance or is built into the parent.

Verification
REQ-035 Reset, memory always ready, 1-cycle response, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8; out_valid first rises 2 cycles after reset falls.
REQ-036 out_ready=0 held with DEPTH=4 -> exactly 4 requests issued, then imem_req_valid stays low; out_ready=1 -> one new request per dequeue.
REQ-037 Redirect to 0x103 with 2 requests inflight:
  - the next 2 responses are dropped;
  - next out_pc = 0x100, then 0x104.
REQ-038 Redirect coincides with out_valid && out_ready -> the head entry is not consumed; the queue is empty the next cycle.
REQ-039 PC = 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-040 FETCH_BYPASS_EN defined, queue empty, response 0x00A00093 at PC 0x20 -> out_valid=1 and out_instr=0x00A00093 in the same cycle.
